// File: rtl/hand_fifo_mem.sv
// DEPTH x WIDTH storage for hand_fifo: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module hand_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hand_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module hand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             data_in_ready,
  output logic             data_out_valid
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic             empty, full;
  logic             wr_fire, rd_fire;
  logic [WIDTH-1:0] mem_rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign data_in_ready  = !full;
  assign data_out_valid = !empty;

  // Ready does not look ahead to a same-cycle pop, so a full FIFO only drains.
  assign wr_fire = wr_en & data_in_ready;
  assign rd_fire = rd_en & data_out_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  hand_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // Gate with valid so unwritten memory never leaks X onto the output.
  assign rd_data = data_out_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_hand_fifo.sv
// Bench for hand_fifo: queue-based reference model, per-cycle output compare,
// directed phases plus randomized read traffic.
module tb_hand_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] rd_data;
  logic             data_in_ready;
  logic             data_out_valid;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [WIDTH-1:0] model_q[$];
  int               pops = 0;
  bit               m_wf, m_rf;

  hand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .wr_data        (wr_data),
    .rd_data        (rd_data),
    .data_in_ready  (data_in_ready),
    .data_out_valid (data_out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      m_wf = wr_en && (model_q.size() < DEPTH);
      m_rf = rd_en && (model_q.size() != 0);
      if (m_rf) begin
        void'(model_q.pop_front());
        pops++;
      end
      if (m_wf) model_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(data_in_ready), 32'(model_q.size() < DEPTH));
      chk("valid", 32'(data_out_valid), 32'(model_q.size() != 0));
      chk("rd_data", 32'(rd_data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
    end
  end

  task automatic cyc(input logic we, input logic re, input logic [WIDTH-1:0] d);
    @(negedge clk);
    #1;
    wr_en   = we;
    rd_en   = re;
    wr_data = d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic drain_in_order(input int first, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk(name, 32'(rd_data), 32'((first + i) & 8'hFF));
    end
    idle();
    chk({name, "_empty"}, 32'(data_out_valid), 32'h0);
  endtask

  logic [31:0] pat;
  int          pops_start;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready", 32'(data_in_ready), 32'h1);
    chk("rst_valid", 32'(data_out_valid), 32'h0);
    chk("rst_data", 32'(rd_data), 32'h0);
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);
    idle();
    chk("rst_rdpulse_valid", 32'(data_out_valid), 32'h0);
    chk("rst_rdpulse_ready", 32'(data_in_ready), 32'h1);

    // Single word
    cyc(1'b1, 1'b0, 8'h01);
    idle();
    chk("single_valid", 32'(data_out_valid), 32'h1);
    chk("single_data", 32'(rd_data), 32'h01);
    cyc(1'b0, 1'b1, '0);
    idle();
    chk("single_pop_valid", 32'(data_out_valid), 32'h0);
    chk("single_pop_data", 32'(rd_data), 32'h0);

    // Fill then drain
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 8'(i));
    idle();
    chk("full_ready", 32'(data_in_ready), 32'h0);
    chk("full_model_size", 32'(model_q.size()), 32'd32);
    cyc(1'b1, 1'b0, 8'hFF);
    idle();
    chk("overflow_size", 32'(model_q.size()), 32'd32);
    chk("overflow_head", 32'(rd_data), 32'h01);
    drain_in_order(1, DEPTH, "drain");

    // Wrap-around
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    drain_in_order(8'h40, 20, "pre_wrap");
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      chk("wrap_ready_before_full", 32'(data_in_ready), 32'h1);
    end
    idle();
    chk("wrap_full", 32'(data_in_ready), 32'h0);
    drain_in_order(1, DEPTH, "wrap_drain");

    // Simultaneous with 5 queued
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h20 + k));
      chk("simul_head", 32'(rd_data), (k < 5) ? 32'(8'h10 + k) : 32'(8'h20 + k - 5));
    end
    idle();
    chk("simul_occupancy", 32'(model_q.size()), 32'd5);
    drain_in_order(8'h25, 5, "simul_drain");

    // Simultaneous while empty
    cyc(1'b1, 1'b1, 8'h55);
    idle();
    chk("simul_empty_valid", 32'(data_out_valid), 32'h1);
    chk("simul_empty_data", 32'(rd_data), 32'h55);
    drain_in_order(8'h55, 1, "simul_empty_drain");

    // Simultaneous while full
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b1, 8'h99);
    idle();
    chk("simul_full_size", 32'(model_q.size()), 32'd31);
    chk("simul_full_ready", 32'(data_in_ready), 32'h1);
    chk("simul_full_head", 32'(rd_data), 32'h02);
    drain_in_order(2, DEPTH - 1, "simul_full_drain");

    // Random read traffic
    pat = $urandom;
    pops_start = pops;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, pat[0], 8'(i));
      pat = {pat[0], pat[31:1]};
      cyc(1'b0, pat[0], '0);
      pat = {pat[0], pat[31:1]};
    end
    for (int i = 0; i < 2 * DEPTH && data_out_valid; i++) cyc(1'b0, 1'b1, '0);
    idle();
    chk("rand_empty", 32'(data_out_valid), 32'h0);
    chk("rand_pop_count", 32'(pops - pops_start), 32'd32);

    // Mid-operation asynchronous reset
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    idle();
    chk("pre_rst_head", 32'(rd_data), 32'h60);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(data_out_valid), 32'h0);
    chk("async_rst_ready", 32'(data_in_ready), 32'h1);
    chk("async_rst_data", 32'(rd_data), 32'h0);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 8'hAA);
    idle();
    chk("post_rst_head", 32'(rd_data), 32'hAA);
    drain_in_order(8'hAA, 1, "post_rst_drain");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
